// File: rtl/result_collector_pkg.sv
// Shared types for the result collector: per-bank state encoding and index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   bank_state_t   EMPTY / FILLING / FULL / DRAINING lifecycle of one row bank
//   idx_width()    word-index width for a given row length (never below 1 bit)
package result_collector_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam int DEFAULT_ARRAY_SIZE = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_ARRAY_SIZE);

endpackage

// File: rtl/rc_bank.sv
// One row bank: word storage, written-bitmap, completion pulse and lifecycle state.
// Latency: write visible in storage/bitmap one edge after it is sampled; read is combinational.
// Backpressure: none; writes arriving while FULL or DRAINING are refused (accept=0).
//
// Ports:
//   clk, srstn              clock, synchronous active-low reset (state/bitmap only)
//   we, waddr, wdata        write request aimed at this bank
//   start_drain             FULL -> DRAINING
//   release_row             DRAINING -> EMPTY, bitmap cleared
//   rd_idx, rd_data         combinational read port for the drain side
//   state                   current bank state
//   accept                  this cycle's write is stored
//   fill_done               this cycle's write completes the row (bank is FULL after the edge)
module rc_bank
  import result_collector_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          we,
  input  logic [$clog2(ARRAY_SIZE)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          start_drain,
  input  logic                          release_row,
  input  logic [$clog2(ARRAY_SIZE)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output bank_state_t                   state,
  output logic                          accept,
  output logic                          fill_done
);

  logic [DATA_WIDTH-1:0] mem [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] bitmap_q;
  logic [ARRAY_SIZE-1:0] bitmap_d;
  logic [ARRAY_SIZE-1:0] wr_onehot;
  bank_state_t           state_q;
  bank_state_t           state_d;

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    accept    = 1'b0;
    fill_done = 1'b0;
    wr_onehot = '0;
    wr_onehot[waddr] = 1'b1;
    case (state_q)
      BANK_EMPTY, BANK_FILLING: begin
        if (we) begin
          accept   = 1'b1;
          // A duplicate address leaves the bitmap as it was; only the data changes.
          bitmap_d = bitmap_q | wr_onehot;
          if (&bitmap_d) begin
            state_d   = BANK_FULL;
            fill_done = 1'b1;
          end else begin
            state_d   = BANK_FILLING;
          end
        end
      end
      BANK_FULL: begin
        if (start_drain) begin
          state_d = BANK_DRAINING;
        end
      end
      BANK_DRAINING: begin
        if (release_row) begin
          state_d  = BANK_EMPTY;
          bitmap_d = '0;
        end
      end
      default: begin
        state_d  = BANK_EMPTY;
        bitmap_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q  <= BANK_EMPTY;
      bitmap_q <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
    end
  end

  // Storage is deliberately not reset; the bitmap alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data = mem[rd_idx];
  assign state   = state_q;

endmodule

// File: rtl/result_collector.sv
// Reassembles ARRAY_SIZE-word rows from an out-of-order word write stream and drains them in index order.
// Latency: completing write sampled at edge E -> out_valid high after edge E+1; back-to-back rows drain with no bubble.
// Backpressure: valid/ready on the drain side holds data/idx/last; the write side never stalls, refused writes set sticky overflow.
//
// Build option: define RESULT_COLLECTOR_DOUBLE_BUF_EN for two ping-pong banks (fill during drain);
// without it a single bank is used and every write while FULL or DRAINING is dropped.
//
// Ports:
//   clk, srstn                         clock, synchronous active-low reset
//   in_we, in_waddr, in_wdata          incoming word write stream
//   out_valid, out_ready               drain handshake
//   out_data, out_idx, out_last        drained word, its index, last-word flag
//   out_row_id                         count of fully drained rows (wraps)
//   overflow, ovf_clr                  sticky dropped-write flag and its clear (clear wins)
module result_collector
  import result_collector_pkg::*;
#(
  parameter int ARRAY_SIZE   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROW_ID_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          in_we,
  input  logic [$clog2(ARRAY_SIZE)-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0]         in_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0] out_idx,
  output logic                          out_last,
  output logic [ROW_ID_WIDTH-1:0]       out_row_id,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(ARRAY_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(ARRAY_SIZE - 1);

`ifdef RESULT_COLLECTOR_DOUBLE_BUF_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif

  logic [NBANKS-1:0]     fill_sel;
  logic [NBANKS-1:0]     drain_sel;
  logic [NBANKS-1:0]     bank_we;
  logic [NBANKS-1:0]     bank_start;
  logic [NBANKS-1:0]     bank_release;
  logic [NBANKS-1:0]     bank_accept;
  logic [NBANKS-1:0]     bank_fill_done;
  bank_state_t           bank_state   [NBANKS];
  logic [DATA_WIDTH-1:0] bank_rd_data [NBANKS];

  logic [AW-1:0]           drain_idx;
  logic [ROW_ID_WIDTH-1:0] row_id;
  logic                    ovf_q;
  logic                    drain_active;
  logic [DATA_WIDTH-1:0]   drain_data;
  logic                    hs;
  logic                    last_hs;
  logic                    drop;

  // ---------------------------------------------------------------------------
  // Bank pointers
  // ---------------------------------------------------------------------------
`ifdef RESULT_COLLECTOR_DOUBLE_BUF_EN
  logic fill_ptr;
  logic drain_ptr;

  assign fill_sel  = {fill_ptr, ~fill_ptr};
  assign drain_sel = {drain_ptr, ~drain_ptr};

  // The fill pointer moves on the completing write itself, so the very next
  // cycle's write already lands in the other bank.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else begin
      if (|(bank_fill_done & fill_sel)) begin
        fill_ptr <= ~fill_ptr;
      end
      if (last_hs) begin
        drain_ptr <= ~drain_ptr;
      end
    end
  end
`else
  logic unused_fill_done;

  // With one bank, both roles always point at it; the completion pulse has no pointer to move.
  assign fill_sel         = 1'b1;
  assign drain_sel        = 1'b1;
  assign unused_fill_done = |bank_fill_done;
`endif

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign bank_we[b]      = in_we & fill_sel[b];
    // A FULL bank starts draining when it is the drain bank, or on the edge the
    // current drain bank hands off, so consecutive rows leave no idle cycle.
    assign bank_start[b]   = (bank_state[b] == BANK_FULL) & (drain_sel[b] | last_hs);
    assign bank_release[b] = last_hs & drain_sel[b];

    rc_bank #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk         (clk),
      .srstn       (srstn),
      .we          (bank_we[b]),
      .waddr       (in_waddr),
      .wdata       (in_wdata),
      .start_drain (bank_start[b]),
      .release_row (bank_release[b]),
      .rd_idx      (drain_idx),
      .rd_data     (bank_rd_data[b]),
      .state       (bank_state[b]),
      .accept      (bank_accept[b]),
      .fill_done   (bank_fill_done[b])
    );
  end

  // ---------------------------------------------------------------------------
  // Drain-side selection
  // ---------------------------------------------------------------------------
  always_comb begin
    drain_active = 1'b0;
    drain_data   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (drain_sel[b]) begin
        drain_active = (bank_state[b] == BANK_DRAINING);
        drain_data   = bank_rd_data[b];
      end
    end
  end

  assign hs      = drain_active & out_ready;
  assign last_hs = hs & (drain_idx == LAST_IDX);

  // Bank state is the pre-edge value, so a write racing a bank release is still refused.
  assign drop    = in_we & ~(|bank_accept);

  // ---------------------------------------------------------------------------
  // Drain counter, row counter, overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srstn) begin
      drain_idx <= '0;
      row_id    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (hs) begin
        drain_idx <= last_hs ? '0 : drain_idx + AW'(1);
      end
      if (last_hs) begin
        row_id <= row_id + ROW_ID_WIDTH'(1);
      end
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign out_valid  = drain_active;
  assign out_data   = drain_active ? drain_data : '0;
  assign out_idx    = drain_idx;
  assign out_last   = drain_active & (drain_idx == LAST_IDX);
  assign out_row_id = row_id;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (ARRAY_SIZE=32, DATA_WIDTH=32, ROW_ID_WIDTH=16).
// Scenarios follow the build: RESULT_COLLECTOR_DOUBLE_BUF_EN selects the double-buffer
// scenario, otherwise the single-buffer drop scenario runs.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        in_we = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [15:0] out_row_id;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] cap_data [64];
  logic [4:0]  cap_idx  [64];
  logic        cap_last [64];
  int          ncap;
  int          gaps;

  result_collector #(
    .ARRAY_SIZE   (32),
    .DATA_WIDTH   (32),
    .ROW_ID_WIDTH (16)
  ) dut (
    .clk        (clk),
    .srstn      (srstn),
    .in_we      (in_we),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_row_id (out_row_id),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input int row, input int i);
    return 32'h5A00_0000 | 32'(row << 8) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    in_we    = 1'b1;
    in_waddr = 5'(a);
    in_wdata = d;
    tick();
    in_we    = 1'b0;
  endtask

  task automatic write_row(input int row);
    for (int i = 0; i < 32; i++) write_word(i, pat(row, i));
  endtask

  // Accepts up to n words with out_ready=1, recording what was seen; gaps counts
  // idle cycles after the first word.
  task automatic capture(input int n, input int budget);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    gaps = 0;
    out_ready = 1'b1;
    while (k < n && cyc < budget) begin
      if (out_valid) begin
        cap_data[k] = out_data;
        cap_idx[k]  = out_idx;
        cap_last[k] = out_last;
        k++;
      end else if (k > 0) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    ncap = k;
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL rst_data: got %h want 0", out_data); end
    tests++; if (out_idx !== 5'd0) begin fails++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", out_last); end
    tests++; if (out_row_id !== 16'd0) begin fails++; $display("FAIL rst_row_id: got %0d want 0", out_row_id); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    srstn = 1'b1;
    tick();
  endtask

  task automatic test_consecutive();
    logic [37:0] got;
    logic [37:0] exp;
    out_ready = 1'b1;
    write_row(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cons_valid_after_E: got %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL cons_valid_after_E1: got %b want 1", out_valid); end
    capture(32, 80);
    tests++; if (ncap !== 32) begin fails++; $display("FAIL cons_count: got %0d want 32", ncap); end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL cons_gaps: got %0d want 0", gaps); end
    for (int i = 0; i < ncap; i++) begin
      got = {cap_idx[i], cap_last[i], cap_data[i]};
      exp = {5'(i), (i == 31), pat(1, i)};
      tests++; if (got !== exp) begin fails++; $display("FAIL cons_word%0d: got %h want %h", i, got, exp); end
    end
    tests++; if (out_row_id !== 16'd1) begin fails++; $display("FAIL cons_row_id: got %0d want 1", out_row_id); end
    tests++; if ({out_valid, out_data} !== 33'h0) begin fails++; $display("FAIL cons_idle_out: got %h want 0", {out_valid, out_data}); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp;
    out_ready = 1'b0;
    for (int a = 31; a >= 5; a--) write_word(a, pat(2, a));
    write_word(5, 32'hDEAD_BEEF);
    for (int a = 4; a >= 0; a--) write_word(a, pat(2, a));
    capture(32, 80);
    tests++; if (ncap !== 32) begin fails++; $display("FAIL ooo_count: got %0d want 32", ncap); end
    for (int i = 0; i < ncap; i++) begin
      exp = (i == 5) ? 32'hDEAD_BEEF : pat(2, i);
      tests++; if ({cap_idx[i], cap_data[i]} !== {5'(i), exp}) begin
        fails++; $display("FAIL ooo_word%0d: got idx %0d data %h want idx %0d data %h", i, cap_idx[i], cap_data[i], i, exp);
      end
    end
    tests++; if (out_row_id !== 16'd2) begin fails++; $display("FAIL ooo_row_id: got %0d want 2", out_row_id); end
  endtask

  task automatic test_backpressure();
    int c;
    out_ready = 1'b0;
    write_row(3);
    for (c = 0; c < 8 && !out_valid; c++) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    for (c = 0; c < 40 && out_idx != 5'd7; c++) tick();
    out_ready = 1'b0;
    tests++; if (out_idx !== 5'd7) begin fails++; $display("FAIL bp_reach7: got %0d want 7", out_idx); end
    for (int h = 0; h < 5; h++) begin
      tick();
      tests++; if ({out_valid, out_idx, out_data} !== {1'b1, 5'd7, pat(3, 7)}) begin
        fails++; $display("FAIL bp_hold%0d: got %b/%0d/%h want 1/7/%h", h, out_valid, out_idx, out_data, pat(3, 7));
      end
    end
    capture(25, 80);
    tests++; if (ncap !== 25) begin fails++; $display("FAIL bp_count: got %0d want 25", ncap); end
    for (int k = 0; k < ncap; k++) begin
      tests++; if ({cap_idx[k], cap_last[k], cap_data[k]} !== {5'(k + 7), (k == 24), pat(3, k + 7)}) begin
        fails++; $display("FAIL bp_word%0d: got %0d/%b/%h want %0d/%b/%h", k, cap_idx[k], cap_last[k], cap_data[k], k + 7, (k == 24), pat(3, k + 7));
      end
    end
    tests++; if (out_row_id !== 16'd3) begin fails++; $display("FAIL bp_row_id: got %0d want 3", out_row_id); end
  endtask

`ifdef RESULT_COLLECTOR_DOUBLE_BUF_EN
  task automatic test_double_buffer();
    logic [31:0] exp;
    fork
      begin
        write_row(4);
        write_row(5);
      end
      capture(64, 200);
    join
    tests++; if (ncap !== 64) begin fails++; $display("FAIL db_count: got %0d want 64", ncap); end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL db_gaps: got %0d want 0", gaps); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL db_no_ovf: got %b want 0", overflow); end
    for (int k = 0; k < ncap; k++) begin
      exp = pat((k < 32) ? 4 : 5, k % 32);
      tests++; if ({cap_idx[k], cap_data[k]} !== {5'(k % 32), exp}) begin
        fails++; $display("FAIL db_word%0d: got %0d/%h want %0d/%h", k, cap_idx[k], cap_data[k], k % 32, exp);
      end
    end
    tests++; if (out_row_id !== 16'd5) begin fails++; $display("FAIL db_row_id: got %0d want 5", out_row_id); end

    // Both banks occupied with the host stalled: the third row is refused.
    out_ready = 1'b0;
    write_row(6);
    write_row(7);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL db_two_rows_no_ovf: got %b want 0", overflow); end
    write_word(0, 32'hBAD0_0000);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL db_third_row_ovf: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL db_ovf_clr: got %b want 0", overflow); end
    ovf_clr = 1'b1;
    write_word(1, 32'hBAD0_0001);
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL db_clr_priority: got %b want 0", overflow); end
    write_word(2, 32'hBAD0_0002);
    capture(64, 200);
    tests++; if (ncap !== 64) begin fails++; $display("FAIL db2_count: got %0d want 64", ncap); end
    for (int k = 0; k < ncap; k++) begin
      exp = pat((k < 32) ? 6 : 7, k % 32);
      tests++; if ({cap_idx[k], cap_data[k]} !== {5'(k % 32), exp}) begin
        fails++; $display("FAIL db2_word%0d: got %0d/%h want %0d/%h", k, cap_idx[k], cap_data[k], k % 32, exp);
      end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL db_ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++; if (out_row_id !== 16'd7) begin fails++; $display("FAIL db2_row_id: got %0d want 7", out_row_id); end
  endtask
`else
  task automatic test_single_buffer();
    out_ready = 1'b0;
    write_row(4);
    for (int c = 0; c < 8 && !out_valid; c++) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sb_valid: got %b want 1", out_valid); end
    write_word(3, 32'hBAD0_0003);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL sb_ovf: got %b want 1", overflow); end
    capture(32, 80);
    tests++; if (ncap !== 32) begin fails++; $display("FAIL sb_count: got %0d want 32", ncap); end
    for (int k = 0; k < ncap; k++) begin
      tests++; if ({cap_idx[k], cap_data[k]} !== {5'(k), pat(4, k)}) begin
        fails++; $display("FAIL sb_word%0d: got %0d/%h want %0d/%h", k, cap_idx[k], cap_data[k], k, pat(4, k));
      end
    end
    tests++; if (out_row_id !== 16'd4) begin fails++; $display("FAIL sb_row_id: got %0d want 4", out_row_id); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL sb_ovf_clr: got %b want 0", overflow); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    int c;
    out_ready = 1'b0;
    write_row(8);
    for (c = 0; c < 8 && !out_valid; c++) tick();
    out_ready = 1'b1;
    // Extra writes while draining: a partial row (double bank) or dropped words (single bank).
    for (c = 0; c < 40 && out_idx != 5'd10; c++) begin
      in_we    = 1'b1;
      in_waddr = 5'(c);
      in_wdata = pat(9, c);
      tick();
    end
    in_we = 1'b0;
    tests++; if ({out_valid, out_idx} !== {1'b1, 5'd10}) begin fails++; $display("FAIL rmd_reach10: got %b/%0d want 1/10", out_valid, out_idx); end
    srstn = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmd_valid: got %b want 0", out_valid); end
    tests++; if (out_row_id !== 16'd0) begin fails++; $display("FAIL rmd_row_id: got %0d want 0", out_row_id); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmd_overflow: got %b want 0", overflow); end
    tests++; if (out_idx !== 5'd0) begin fails++; $display("FAIL rmd_idx: got %0d want 0", out_idx); end
    srstn = 1'b1;
    out_ready = 1'b0;
    write_row(10);
    capture(32, 80);
    tests++; if (ncap !== 32) begin fails++; $display("FAIL rmd_count: got %0d want 32", ncap); end
    for (int k = 0; k < ncap; k++) begin
      tests++; if ({cap_idx[k], cap_last[k], cap_data[k]} !== {5'(k), (k == 31), pat(10, k)}) begin
        fails++; $display("FAIL rmd_word%0d: got %0d/%b/%h want %0d/%b/%h", k, cap_idx[k], cap_last[k], cap_data[k], k, (k == 31), pat(10, k));
      end
    end
    tests++; if (out_row_id !== 16'd1) begin fails++; $display("FAIL rmd_row_id_after: got %0d want 1", out_row_id); end
  endtask

  initial begin
    test_reset();
    test_consecutive();
    test_out_of_order();
    test_backpressure();
`ifdef RESULT_COLLECTOR_DOUBLE_BUF_EN
    test_double_buffer();
`else
    test_single_buffer();
`endif
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the output serializer. It consumes the one-word-per-cycle SRAM write stream (we/addr/data) and reassembles each ARRAY_SIZE-word result row in a local bank. Addresses may arrive in any order. Once every index of a row has been written, it drains the row in index order to the host over a valid/ready interface. A second bank, when compiled in, lets one row fill while the previous one drains.

## Interface
Parameters:
- ARRAY_SIZE, 32, words per result row
- DATA_WIDTH, 32, word width (single-precision float)
- ROW_ID_WIDTH, 16, width of the completed-row counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- srstn  in  1  reset, synchronous, active-low
- in_we  in  1  incoming word write strobe
- in_waddr  in  $clog2(ARRAY_SIZE)  word index within the row
- in_wdata  in  DATA_WIDTH  word value
- out_valid  out  1  drain word available
- out_ready  in  1  host accepts the word
- out_data  out  DATA_WIDTH  drained word
- out_idx  out  $clog2(ARRAY_SIZE)  index of out_data
- out_last  out  1  high with idx ARRAY_SIZE-1
- out_row_id  out  ROW_ID_WIDTH  count of fully drained rows
- overflow  out  1  sticky: at least one incoming write was dropped
- ovf_clr  in  1  clears overflow

## Operation
- Each bank has word storage, a written-bitmap and a state: EMPTY, FILLING, FULL or DRAINING.
- Write with in_we=1:
  - Goes to the current fill bank and sets bitmap[in_waddr].
  - EMPTY moves to FILLING on the first write.
  - A duplicate address overwrites the data; the bitmap is unchanged.
- When the bitmap is all ones, the bank becomes FULL and the fill pointer toggles to the other bank (double-buffer build only).
- Dropped writes: a write whose fill bank is FULL or DRAINING is discarded and sets overflow. The stored data is untouched.
- Drain:
  - The drain bank moves FULL → DRAINING.
  - It outputs idx 0..ARRAY_SIZE-1 in order.
  - idx advances on each out_valid && out_ready edge.
  - The handshake at idx ARRAY_SIZE-1 clears the bitmap, sets the bank to EMPTY, increments out_row_id (wrapping at 2^ROW_ID_WIDTH) and toggles the drain pointer.
- out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0. out_data is 0 when out_valid=0.
- Priority: ovf_clr has priority over a same-cycle overflow set, so overflow ends at 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, out_row_id=0, overflow=0, both banks EMPTY, both pointers at bank 0. Storage contents are not reset.
- Reset mid-operation discards all partial and full rows.
- Edge E samples the completing write; the bank is FULL after E; out_valid=1 after edge E+1.
- Back-to-back rows: if the other bank is FULL when the last handshake completes, out_valid stays 1 with no bubble, and idx restarts at 0.
- A write to the drain bank on the same edge it is released to EMPTY is dropped and counted as overflow, because bank state is sampled before the edge.
- Writes to the fill bank are accepted every cycle with no stall.

## Configuration
- RESULT_COLLECTOR_DOUBLE_BUF_EN
  - Defined: two banks ping-pong, and filling continues during a drain.
  - Undefined: one bank only; every write while FULL or DRAINING is dropped and sets overflow.

## Structure
- Package result_collector_pkg: bank state enum (EMPTY/FILLING/FULL/DRAINING) and the address-width helper constant.
- Sub-module rc_bank: storage, bitmap, full flag and state for one row. Instantiated once or twice.
- Top level: pointers, drain counter, handshake logic and overflow logic.

## Test plan
- Consecutive row: ARRAY_SIZE=32, addresses 0..31 on 32 consecutive cycles, out_ready=1.
  - out_valid is 1 two edges after the final write.
  - 32 words arrive with idx 0..31 and data matching.
  - out_last is 1 only at idx 31; out_row_id goes 0→1.
- Out-of-order fill: addresses 31..0 plus a duplicate write to addr 5 of 0xDEAD_BEEF.
  - Drain is still in order 0..31; idx 5 outputs 0xDEAD_BEEF.
- Backpressure: out_ready=0 for 5 cycles at idx 7.
  - out_data and out_idx hold the idx-7 values; then the drain resumes with no word lost.
- Double buffer:
  - Two back-to-back rows with out_ready=1 give 64 words with no gap and overflow=0.
  - A third row with out_ready=0 throughout sets overflow at its first write; rows 1 and 2 drain intact.
  - ovf_clr=1 then returns overflow to 0.
- Reset mid-drain: srstn=0 at idx 10.
  - The next cycle shows out_valid=0, out_row_id=0, overflow=0.
  - A subsequent full row drains normally.
- Single-buffer build (macro undefined): a write during the drain is dropped, overflow=1, and the drained data is unchanged.
